// File: rtl/axi_burst_splitter_if.sv
// Bundle of the user command port, the AXI4 AW/AR/B/R channels and the write-length hand-off.
// "master" is the burst splitter side, "slave" is the AXI slave / command issuer side.
interface axi_burst_splitter_if #(
    parameter int ADDR_WIDTH       = 32,
    parameter int MAX_PACKET_WIDTH = 13
);
    logic                        cmd_en;
    logic                        cmd_wr_rd;
    logic [ADDR_WIDTH-1:0]       cmd_addr;
    logic                        cmd_adr_fixed_en;
    logic [MAX_PACKET_WIDTH-1:0] cmd_data_count;
    logic                        cmd_ack;
    logic                        cmd_error;

    logic [ADDR_WIDTH-1:0]       awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic [3:0]                  awid;
    logic                        awvalid;
    logic                        awready;

    logic [ADDR_WIDTH-1:0]       araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic [3:0]                  arid;
    logic                        arvalid;
    logic                        arready;

    logic                        bvalid;
    logic [1:0]                  bresp;
    logic                        bready;

    logic                        rvalid;
    logic                        rready;
    logic                        rlast;
    logic [1:0]                  rresp;

    logic                        blen_valid;
    logic [8:0]                  blen;
    logic                        blen_ready;

    modport master (
        input  cmd_en, cmd_wr_rd, cmd_addr, cmd_adr_fixed_en, cmd_data_count,
        output cmd_ack, cmd_error,
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        input  awready,
        output araddr, arlen, arsize, arburst, arid, arvalid,
        input  arready,
        input  bvalid, bresp,
        output bready,
        input  rvalid, rready, rlast, rresp,
        output blen_valid, blen,
        input  blen_ready
    );

    modport slave (
        output cmd_en, cmd_wr_rd, cmd_addr, cmd_adr_fixed_en, cmd_data_count,
        input  cmd_ack, cmd_error,
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        output awready,
        input  araddr, arlen, arsize, arburst, arid, arvalid,
        output arready,
        output bvalid, bresp,
        input  bready,
        output rvalid, rready, rlast, rresp,
        input  blen_valid, blen,
        output blen_ready
    );
endinterface

// File: rtl/axi_burst_splitter.sv
// Splits one user command into AXI4 AW/AR bursts bounded by 4KB pages and the burst cap,
// tracks outstanding bursts and acks the command once every B / final R beat has returned.
module axi_burst_splitter #(
    parameter int         ADDR_WIDTH       = 32,
    parameter int         DATA_WIDTH       = 32,
    parameter int         MAX_PACKET_SIZE  = 4096,
    parameter int         MAX_PACKET_WIDTH = 13,
    parameter int         MAX_BURST_LEN    = 256,
    parameter int         MAX_OUTSTANDING  = 4,
    parameter logic [3:0] AXI_ID           = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_burst_splitter_if.master bus
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int SIZE      = $clog2(BYTES);
    localparam int FIXED_CAP = (MAX_BURST_LEN < 16) ? MAX_BURST_LEN : 16;
    localparam int LW        = ($clog2(MAX_PACKET_SIZE) + 2 > 14) ? $clog2(MAX_PACKET_SIZE) + 2 : 14;
    localparam int OW        = 5;
    localparam int PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                      state_reg, state_next;
    logic                        wr_reg;
    logic                        fixed_reg;
    logic [ADDR_WIDTH-1:0]       addr_reg;
    logic [MAX_PACKET_WIDTH-1:0] remaining_reg;
    logic [7:0]                  axlen_reg;
    logic                        valid_reg;
    logic [OW-1:0]               outstanding_reg, outstanding_next;
    logic                        error_reg;

    logic [8:0]                  fifo_mem [0:MAX_OUTSTANDING-1];
    logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg;
    logic [OW-1:0]               fifo_count_reg, fifo_count_next;

    logic                        active;
    logic                        handshake;
    logic                        resp_done;
    logic                        resp_err;
    logic                        bready_int;
    logic                        raise;
    logic                        fifo_full;
    logic                        push_ok;
    logic                        pop;
    logic [12:0]                 to4k_bytes;
    logic [LW-1:0]               to4k_beats;
    logic [LW-1:0]               rem_ext;
    logic [LW-1:0]               cap;
    logic [LW-1:0]               len_min;
    logic [8:0]                  len_calc;
    logic [8:0]                  burst_len;
    logic [ADDR_WIDTH-1:0]       align_mask;

    assign align_mask = {ADDR_WIDTH{1'b1}} << SIZE;

    // Burst length: the smallest of beats left, the burst cap, and (INCR only) beats to the 4KB page end.
    assign to4k_bytes = 13'h1000 - {1'b0, addr_reg[11:0]};
    assign to4k_beats = LW'(to4k_bytes >> SIZE);
    assign rem_ext    = LW'(remaining_reg);
    assign cap        = fixed_reg ? LW'(FIXED_CAP) : LW'(MAX_BURST_LEN);

    always_comb begin
        len_min = (rem_ext < cap) ? rem_ext : cap;
        if (!fixed_reg && (to4k_beats < len_min)) begin
            len_min = to4k_beats;
        end
    end

    assign len_calc  = 9'(len_min);
    assign burst_len = {1'b0, axlen_reg} + 9'd1;

    assign active     = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign handshake  = valid_reg & (wr_reg ? bus.awready : bus.arready);
    assign bready_int = active & wr_reg;
    assign resp_done  = active & (wr_reg ? (bus.bvalid & bready_int)
                                         : (bus.rvalid & bus.rready & bus.rlast));
    assign resp_err   = active & (wr_reg ? (bus.bvalid & bready_int & (bus.bresp != 2'b00))
                                         : (bus.rvalid & bus.rready & (bus.rresp != 2'b00)));

    assign fifo_full = (fifo_count_reg == OW'(MAX_OUTSTANDING));
    assign pop       = bus.blen_valid & bus.blen_ready;
    assign push_ok   = handshake & wr_reg & (~fifo_full | pop);

    // A new burst is only offered once the previous one has been accepted and there is room to track it.
    assign raise = (state_reg == ISSUE) && !valid_reg
                && (outstanding_reg < OW'(MAX_OUTSTANDING))
                && !(wr_reg && fifo_full);

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({handshake, resp_done})
            2'b10:   outstanding_next = outstanding_reg + OW'(1);
            2'b01:   outstanding_next = (outstanding_reg != '0) ? outstanding_reg - OW'(1) : outstanding_reg;
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_en) begin
                    state_next = (bus.cmd_data_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (handshake && (remaining_reg == MAX_PACKET_WIDTH'(burst_len))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!bus.cmd_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_reg          <= 1'b0;
            fixed_reg       <= 1'b0;
            addr_reg        <= '0;
            remaining_reg   <= '0;
            axlen_reg       <= '0;
            valid_reg       <= 1'b0;
            outstanding_reg <= '0;
            error_reg       <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && bus.cmd_en) begin
                wr_reg        <= bus.cmd_wr_rd;
                fixed_reg     <= bus.cmd_adr_fixed_en;
                addr_reg      <= bus.cmd_addr & align_mask;
                remaining_reg <= bus.cmd_data_count;
                error_reg     <= 1'b0;
            end
            if (raise) begin
                valid_reg <= 1'b1;
                axlen_reg <= 8'(len_calc - 9'd1);
            end
            if (handshake) begin
                valid_reg     <= 1'b0;
                remaining_reg <= remaining_reg - MAX_PACKET_WIDTH'(burst_len);
                if (!fixed_reg) begin
                    addr_reg <= addr_reg + (ADDR_WIDTH'(burst_len) << SIZE);
                end
            end
            if (resp_err) begin
                error_reg <= 1'b1;
            end
            outstanding_reg <= outstanding_next;
        end
    end

    // Write-length FIFO: first-word-fall-through, storage kept reset-free so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= burst_len;
        end
    end

    always_comb begin
        fifo_count_next = fifo_count_reg;
        case ({push_ok, pop})
            2'b10:   fifo_count_next = fifo_count_reg + OW'(1);
            2'b01:   fifo_count_next = fifo_count_reg - OW'(1);
            default: fifo_count_next = fifo_count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            fifo_count_reg <= fifo_count_next;
        end
    end

    assign bus.blen_valid = (fifo_count_reg != '0);
    assign bus.blen       = bus.blen_valid ? fifo_mem[rd_ptr_reg] : 9'd0;

    // Address channel fields read as zero whenever their channel is not presenting a burst.
    assign bus.awvalid = valid_reg & wr_reg;
    assign bus.awaddr  = bus.awvalid ? addr_reg : '0;
    assign bus.awlen   = bus.awvalid ? axlen_reg : 8'd0;
    assign bus.awsize  = bus.awvalid ? 3'(SIZE) : 3'd0;
    assign bus.awburst = bus.awvalid ? (fixed_reg ? 2'b00 : 2'b01) : 2'b00;
    assign bus.awid    = bus.awvalid ? AXI_ID : 4'd0;

    assign bus.arvalid = valid_reg & ~wr_reg;
    assign bus.araddr  = bus.arvalid ? addr_reg : '0;
    assign bus.arlen   = bus.arvalid ? axlen_reg : 8'd0;
    assign bus.arsize  = bus.arvalid ? 3'(SIZE) : 3'd0;
    assign bus.arburst = bus.arvalid ? (fixed_reg ? 2'b00 : 2'b01) : 2'b00;
    assign bus.arid    = bus.arvalid ? AXI_ID : 4'd0;

    assign bus.bready    = bready_int;
    assign bus.cmd_ack   = (state_reg == DONE);
    assign bus.cmd_error = (state_reg == DONE) & error_reg;
endmodule

// File: tb/tb_axi_burst_splitter.sv
// Directed bench for axi_burst_splitter: expected bursts, write lengths and acks are queued at issue
// time and popped by independent monitors whenever the DUT presents them.
module tb_axi_burst_splitter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   done_cyc;
    int   aw_total;
    int   b_total;
    int   b_pend;
    bit   hold_b;
    logic ack_prev;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ax_t;

    typedef struct packed {
        logic err;
        logic lat;
    } ack_t;

    ax_t        exp_aw[$];
    ax_t        exp_ar[$];
    int         exp_blen[$];
    ack_t       exp_ack[$];
    logic [1:0] bresp_cfg[$];
    int         ar_pend[$];

    axi_burst_splitter_if #(.ADDR_WIDTH(32), .MAX_PACKET_WIDTH(13)) bus ();

    axi_burst_splitter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_PACKET_SIZE(4096), .MAX_PACKET_WIDTH(13),
        .MAX_BURST_LEN(256), .MAX_OUTSTANDING(4), .AXI_ID(4'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_burst(input bit wr, input logic [31:0] addr, input int beats, input bit fixed);
        ax_t e;
        e.addr  = addr;
        e.len   = 8'(beats - 1);
        e.burst = fixed ? 2'b00 : 2'b01;
        if (wr) begin
            exp_aw.push_back(e);
            exp_blen.push_back(beats);
        end else begin
            exp_ar.push_back(e);
        end
    endtask

    task automatic exp_done(input logic err, input logic lat);
        ack_t a;
        a.err = err;
        a.lat = lat;
        exp_ack.push_back(a);
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic fixed, input int cnt);
        int guard;
        @(posedge clk); #1;
        bus.cmd_en           = 1'b1;
        bus.cmd_wr_rd        = wr;
        bus.cmd_addr         = addr;
        bus.cmd_adr_fixed_en = fixed;
        bus.cmd_data_count   = 13'(cnt);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.cmd_ack && guard < 5000);
        checks++;
        if (!bus.cmd_ack) begin
            errors++;
            $display("FAIL cmd_ack_timeout: ack=%0b after %0d cycles, required ack=1", bus.cmd_ack, guard);
        end
        @(posedge clk); #1;
        bus.cmd_en = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Address write monitor
    always @(negedge clk) begin
        ax_t e;
        if (rst_n && bus.awvalid && bus.awready) begin
            aw_total++;
            b_pend++;
            checks++;
            if (exp_aw.size() == 0) begin
                errors++;
                $display("FAIL aw_unexpected: addr=%h len=%0d, required no burst", bus.awaddr, bus.awlen);
            end else begin
                e = exp_aw.pop_front();
                $display("AW addr=%h len=%0d burst=%0d", bus.awaddr, bus.awlen, bus.awburst);
                if (bus.awaddr !== e.addr || bus.awlen !== e.len || bus.awburst !== e.burst ||
                    bus.awsize !== 3'd2 || bus.awid !== 4'd0) begin
                    errors++;
                    $display("FAIL aw_burst: addr=%h len=%0d burst=%0d size=%0d id=%0d, required addr=%h len=%0d burst=%0d size=2 id=0",
                             bus.awaddr, bus.awlen, bus.awburst, bus.awsize, bus.awid, e.addr, e.len, e.burst);
                end
            end
        end
    end

    // Address read monitor
    always @(negedge clk) begin
        ax_t e;
        if (rst_n && bus.arvalid && bus.arready) begin
            ar_pend.push_back(int'(bus.arlen));
            checks++;
            if (exp_ar.size() == 0) begin
                errors++;
                $display("FAIL ar_unexpected: addr=%h len=%0d, required no burst", bus.araddr, bus.arlen);
            end else begin
                e = exp_ar.pop_front();
                $display("AR addr=%h len=%0d burst=%0d", bus.araddr, bus.arlen, bus.arburst);
                if (bus.araddr !== e.addr || bus.arlen !== e.len || bus.arburst !== e.burst ||
                    bus.arsize !== 3'd2 || bus.arid !== 4'd0) begin
                    errors++;
                    $display("FAIL ar_burst: addr=%h len=%0d burst=%0d size=%0d id=%0d, required addr=%h len=%0d burst=%0d size=2 id=0",
                             bus.araddr, bus.arlen, bus.arburst, bus.arsize, bus.arid, e.addr, e.len, e.burst);
                end
            end
        end
    end

    // Write-length monitor
    always @(negedge clk) begin
        int e;
        if (rst_n && bus.blen_valid && bus.blen_ready) begin
            checks++;
            if (exp_blen.size() == 0) begin
                errors++;
                $display("FAIL blen_unexpected: blen=%0d, required none", bus.blen);
            end else begin
                e = exp_blen.pop_front();
                $display("BLEN %0d", bus.blen);
                if (int'(bus.blen) != e) begin
                    errors++;
                    $display("FAIL blen: got %0d, required %0d", bus.blen, e);
                end
            end
        end
    end

    // Ack monitor: error flag and one-cycle latency after the final completion
    always @(negedge clk) begin
        ack_t a;
        if (bus.cmd_ack && !ack_prev) begin
            checks++;
            if (exp_ack.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: ack=1, required no ack");
            end else begin
                a = exp_ack.pop_front();
                $display("ACK error=%0b cycle=%0d", bus.cmd_error, cyc);
                if (bus.cmd_error !== a.err) begin
                    errors++;
                    $display("FAIL ack_error: got %0b, required %0b", bus.cmd_error, a.err);
                end
                if (a.lat) begin
                    checks++;
                    if (cyc != done_cyc) begin
                        errors++;
                        $display("FAIL ack_latency: ack at cycle %0d, required cycle %0d", cyc, done_cyc);
                    end
                end
            end
        end
        ack_prev = bus.cmd_ack;
    end

    // Write response slave
    initial begin
        int guard;
        forever begin
            @(posedge clk); #1;
            if (b_pend > 0 && !hold_b) begin
                bus.bvalid = 1'b1;
                bus.bresp  = (bresp_cfg.size() > 0) ? bresp_cfg.pop_front() : 2'b00;
                guard = 0;
                while (!bus.bready && guard < 1000) begin
                    @(negedge clk);
                    guard++;
                end
                if (!bus.bready) begin
                    checks++;
                    errors++;
                    $display("FAIL bready_timeout: bready=0, required 1");
                end
                @(posedge clk); #1;
                bus.bvalid = 1'b0;
                bus.bresp  = 2'b00;
                b_pend--;
                b_total++;
                done_cyc = cyc;
            end
        end
    end

    // Read data slave
    initial begin
        int n;
        forever begin
            @(posedge clk); #1;
            if (ar_pend.size() > 0) begin
                n = ar_pend.pop_front();
                for (int b = 0; b <= n; b++) begin
                    bus.rvalid = 1'b1;
                    bus.rlast  = (b == n);
                    bus.rresp  = 2'b00;
                    @(posedge clk); #1;
                end
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
                done_cyc   = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int base_aw;
        int b_before;
        int guard;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        done_cyc = 0;
        aw_total = 0;
        b_total  = 0;
        b_pend   = 0;
        hold_b   = 1'b0;
        ack_prev = 1'b0;
        rst_n    = 1'b0;
        bus.cmd_en = 1'b0; bus.cmd_wr_rd = 1'b0; bus.cmd_addr = '0;
        bus.cmd_adr_fixed_en = 1'b0; bus.cmd_data_count = '0;
        bus.awready = 1'b1; bus.arready = 1'b1;
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.rvalid = 1'b0; bus.rready = 1'b1; bus.rlast = 1'b0; bus.rresp = 2'b00;
        bus.blen_ready = 1'b1;

        #12;
        check_val("reset_awvalid", 32'(bus.awvalid), 32'd0);
        check_val("reset_arvalid", 32'(bus.arvalid), 32'd0);
        check_val("reset_ack", 32'(bus.cmd_ack), 32'd0);
        check_val("reset_blen_valid", 32'(bus.blen_valid), 32'd0);
        check_val("reset_bready", 32'(bus.bready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // single INCR write burst
        exp_burst(1, 32'h0, 16, 0);
        exp_done(1'b0, 1'b1);
        run_cmd(1'b1, 32'h0, 1'b0, 16);

        // write crossing a 4KB page
        exp_burst(1, 32'hFF0, 4, 0);
        exp_burst(1, 32'h1000, 4, 0);
        exp_done(1'b0, 1'b1);
        run_cmd(1'b1, 32'hFF0, 1'b0, 8);

        // long read split by the 256-beat cap
        exp_burst(0, 32'h0, 256, 0);
        exp_burst(0, 32'h400, 256, 0);
        exp_burst(0, 32'h800, 88, 0);
        exp_done(1'b0, 1'b1);
        run_cmd(1'b0, 32'h0, 1'b0, 600);

        // FIXED read capped at 16 beats
        exp_burst(0, 32'h100, 16, 1);
        exp_burst(0, 32'h100, 16, 1);
        exp_burst(0, 32'h100, 8, 1);
        exp_done(1'b0, 1'b1);
        run_cmd(1'b0, 32'h100, 1'b1, 40);

        // outstanding limit with write responses withheld
        for (int i = 0; i < 8; i++) exp_burst(1, 32'(i * 32'h400), 256, 0);
        exp_done(1'b0, 1'b1);
        hold_b  = 1'b1;
        base_aw = aw_total;
        fork
            run_cmd(1'b1, 32'h0, 1'b0, 2048);
            begin
                repeat (40) @(negedge clk);
                check_val("outstanding_aw_count", 32'(aw_total - base_aw), 32'd4);
                check_val("outstanding_awvalid_low", 32'(bus.awvalid), 32'd0);
                b_before = b_total;
                hold_b   = 1'b0;
                guard    = 0;
                while ((aw_total - base_aw) < 5 && guard < 200) begin
                    @(negedge clk);
                    guard++;
                end
                check_val("fifth_aw_seen", 32'(aw_total - base_aw), 32'd5);
                check_val("fifth_aw_after_b", 32'(b_total > b_before), 32'd1);
            end
        join

        // error response on the second of three FIXED write bursts
        exp_burst(1, 32'h200, 16, 1);
        exp_burst(1, 32'h200, 16, 1);
        exp_burst(1, 32'h200, 8, 1);
        bresp_cfg.push_back(2'b00);
        bresp_cfg.push_back(2'b10);
        bresp_cfg.push_back(2'b00);
        exp_done(1'b1, 1'b1);
        run_cmd(1'b1, 32'h200, 1'b1, 40);

        // zero-beat command acks directly with a cleared error flag
        exp_done(1'b0, 1'b0);
        run_cmd(1'b1, 32'h0, 1'b0, 0);

        // reset while a burst is held waiting for AWREADY
        bus.awready = 1'b0;
        @(posedge clk); #1;
        bus.cmd_en = 1'b1; bus.cmd_wr_rd = 1'b1; bus.cmd_addr = 32'h40;
        bus.cmd_adr_fixed_en = 1'b0; bus.cmd_data_count = 13'd2048;
        repeat (5) @(negedge clk);
        check_val("held_awvalid", 32'(bus.awvalid), 32'd1);
        check_val("held_awaddr", bus.awaddr, 32'h40);
        check_val("held_awlen", 32'(bus.awlen), 32'd255);
        check_val("held_bready", 32'(bus.bready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_awvalid", 32'(bus.awvalid), 32'd0);
        check_val("rst_awaddr", bus.awaddr, 32'h0);
        check_val("rst_awlen", 32'(bus.awlen), 32'd0);
        check_val("rst_bready", 32'(bus.bready), 32'd0);
        check_val("rst_ack", 32'(bus.cmd_ack), 32'd0);
        bus.cmd_en  = 1'b0;
        bus.awready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // normal operation after reset
        exp_burst(1, 32'h80, 16, 0);
        exp_done(1'b0, 1'b1);
        run_cmd(1'b1, 32'h80, 1'b0, 16);

        repeat (5) @(posedge clk);
        check_val("left_aw", 32'(exp_aw.size()), 32'd0);
        check_val("left_ar", 32'(exp_ar.size()), 32'd0);
        check_val("left_blen", 32'(exp_blen.size()), 32'd0);
        check_val("left_ack", 32'(exp_ack.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
